// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode-stage forwarding selects, load-use stalls and branch flush bubbles
module decode_hazard_ctrl #(
  parameter int REGISTER_SIZE    = 5,
  parameter int NUM_SRC          = 2,
  parameter int FWD_DEPTH        = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int FLUSH_CYCLES     = 1,
  parameter int SEL_W            = $clog2(FWD_DEPTH+1),
  parameter int CNT_W            = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   dec_valid,
  input  logic [REGISTER_SIZE-1:0]               dec_dest_reg,
  input  logic                                   dec_write_enable,
  input  logic                                   dec_is_load,
  input  logic [NUM_SRC-1:0][REGISTER_SIZE-1:0]  dec_src_reg,
  input  logic [NUM_SRC-1:0]                     dec_src_used,
  input  logic                                   branch_taken,
  output logic                                   f_to_d_enable_ff,
  output logic                                   d_to_e_enable_ff,
  output logic                                   d_to_e_bubble,
  output logic [NUM_SRC-1:0][SEL_W-1:0]          pipeline_forward_sel,
  output logic                                   stall_active,
  output logic                                   flush_active,
  output logic [CNT_W-1:0]                       stall_count
);
  typedef struct packed {
    logic                     v;
    logic [REGISTER_SIZE-1:0] dst;
    logic                     we;
    logic                     ld;
  } entry_t;
  typedef enum logic {IDLE, FLUSH} state_t;
  entry_t                        tbl [FWD_DEPTH];
  state_t                        state, state_nxt;
  logic [2:0]                    fc, fc_nxt;
  logic [NUM_SRC-1:0]            hz;
  logic [NUM_SRC-1:0][SEL_W-1:0] sel_raw;
  // Scan oldest to youngest so the smallest matching index is the one left standing.
  always_comb begin
    hz = '0;
    sel_raw = '0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = FWD_DEPTH-1; k >= 0; k--)
        if (tbl[k].v && tbl[k].we && tbl[k].dst != '0 && tbl[k].dst == dec_src_reg[i] && dec_src_used[i]) begin
          sel_raw[i] = SEL_W'(k+1);
          hz[i] = tbl[k].ld && (k < LOAD_READY_STAGE);
        end
  end
  assign flush_active     = state == FLUSH;
  assign stall_active     = |hz && !flush_active;
  assign f_to_d_enable_ff = !stall_active;
  assign d_to_e_enable_ff = !stall_active;
  assign d_to_e_bubble    = stall_active || flush_active;
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++)
      pipeline_forward_sel[i] = (flush_active || hz[i]) ? '0 : sel_raw[i];
  end
  always_comb begin
    state_nxt = state;
    fc_nxt = fc;
    if (state == IDLE) begin
      state_nxt = (branch_taken && dec_valid && !stall_active) ? FLUSH : IDLE;
      fc_nxt = (branch_taken && dec_valid && !stall_active) ? 3'(FLUSH_CYCLES-1) : fc;
    end else begin
      state_nxt = (fc == 3'd0) ? IDLE : FLUSH;
      fc_nxt = (fc == 3'd0) ? 3'd0 : fc - 3'd1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < FWD_DEPTH; k++) tbl[k] <= '0;
      state <= IDLE;
      fc <= '0;
      stall_count <= '0;
    end else begin
      tbl[0] <= d_to_e_bubble ? '0 : {dec_valid, dec_dest_reg, dec_write_enable, dec_is_load};
      for (int k = 1; k < FWD_DEPTH; k++) tbl[k] <= tbl[k-1];
      state <= state_nxt;
      fc <= fc_nxt;
      if (stall_active && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the decode stage of the pipelined RISC-V core.
- Tracks the destination registers of in-flight instructions in a FWD_DEPTH-entry shift table.
- Drives per-source bypass selects, load-use stalls, and branch-flush bubbles.
- Generalises the fixed two-source, fixed-depth hazard logic with a configurable source count, forwarding depth, load latency, flush length and a stall counter.

Parameters:
- REGISTER_SIZE, 5, register address width.
- NUM_SRC, 2, number of source operands checked per instruction.
- FWD_DEPTH, 3, tracked downstream stages; entry 0 = execute, then memory, then writeback.
- LOAD_READY_STAGE, 1, first table index from which load data can be forwarded.
- FLUSH_CYCLES, 1, bubbles injected into execute after a taken branch/jump (1..7).
- SEL_W, $clog2(FWD_DEPTH+1), forward select width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode holds a valid instruction.
- dec_dest_reg  in  REGISTER_SIZE  rd of decoded instruction.
- dec_write_enable  in  1  decoded instruction writes rd.
- dec_is_load  in  1  decoded instruction is a load.
- dec_src_reg  in  NUM_SRC x REGISTER_SIZE  rs addresses.
- dec_src_used  in  NUM_SRC  per-source "operand read" flag.
- branch_taken  in  1  decoded jump/branch redirects PC this cycle.
- f_to_d_enable_ff  out  1  fetch-to-decode register enable.
- d_to_e_enable_ff  out  1  decode-to-execute register enable.
- d_to_e_bubble  out  1  execute receives a NOP this cycle.
- pipeline_forward_sel  out  NUM_SRC x SEL_W  0 = register file, k+1 = forward from table entry k.
- stall_active  out  1  load-use stall this cycle.
- flush_active  out  1  flush FSM in FLUSH state.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Table entry fields: valid, dest, we, is_load.
- Each clk, entry k+1 <= entry k for k < FWD_DEPTH-1; the last entry is discarded.
- Entry 0 <= {dec_valid, dec_dest_reg, dec_write_enable, dec_is_load} only when d_to_e_bubble = 0; otherwise entry 0 <= all-zero bubble.
- An entry matches source i when: valid, we, dest != 0, dest == dec_src_reg[i], and dec_src_used[i] = 1.
- Forward select for source i: choose the smallest matching k (youngest wins) and output k+1. Output 0 if there is no match or the source is x0.
- Load-use hazard: the youngest match for any source has is_load = 1 and k < LOAD_READY_STAGE.
- On a load-use hazard:
  - stall_active = 1, f_to_d_enable_ff = 0, d_to_e_enable_ff = 0, d_to_e_bubble = 1.
  - The forward select for that source is 0 and is don't-care.
- The stall repeats each cycle until the load reaches LOAD_READY_STAGE; that is exactly LOAD_READY_STAGE - k cycles.
- Forward selects, stall and enable outputs are combinational from the table and current inputs. Table, FSM and counter are registered.
- Flush FSM:
  - States: IDLE, FLUSH. A 3-bit counter fc tracks bubbles.
  - IDLE -> FLUSH when branch_taken & dec_valid & !stall_active; fc <= FLUSH_CYCLES-1.
  - In that IDLE cycle the branch itself enters entry 0 normally.
  - In FLUSH: d_to_e_bubble = 1, f_to_d_enable_ff = 1 (wrong-path fetch overwritten), flush_active = 1, hazard checks masked (stall_active = 0, selects 0).
  - fc decrements each cycle; FLUSH -> IDLE when fc == 0.
- branch_taken asserted while in FLUSH is ignored.
- If stall and branch_taken coincide, the stall wins. The branch re-evaluates once the stall clears.
- stall_count increments on each stall_active cycle and saturates at all-ones; it does not count flush cycles.
- Reset (rst = 0, asynchronous):
  - Table cleared, FSM in IDLE, fc = 0, stall_count = 0.
  - Outputs: f_to_d_enable_ff = 1, d_to_e_enable_ff = 1, d_to_e_bubble = 0, selects 0, stall_active = 0, flush_active = 0.
- Reset mid-stall or mid-flush aborts immediately. The first cycle after deassertion behaves as an empty pipeline.

Test Plan:
- Forwarding: ADD x5 then dependent ADD rs1 = x5 next cycle -> sel[0] = 1. With one independent instruction between -> sel[0] = 2. With two between -> sel[0] = 3. With three between -> sel[0] = 0.
- Load-use: LW x7 then ADD rs2 = x7 -> stall_active = 1 for 1 cycle, f_to_d_enable_ff = 0, d_to_e_bubble = 1. Next cycle sel[1] = 2, stall_count = 1.
- Youngest-wins and x0: two in-flight writes to x3 at entries 0 and 2 -> sel = 1. A source of x0 matching a "write" to x0 -> sel = 0 and no stall.
- Flush with FLUSH_CYCLES = 2: branch_taken -> flush_active high for 2 cycles, 2 bubbles enter the table, no stall even if the decode operands match. A second branch_taken during flush is ignored.
- Stall vs branch: a load-use hazard together with branch_taken -> stall first (1 cycle), then FLUSH entered on the following cycle.
- Reset and saturation: assert rst during FLUSH -> all outputs at reset values asynchronously. With CNT_W = 2, 5 stall cycles -> stall_count = 3.
